// File: rtl/niosii_system_button_debounce_if.sv
// Button bundle between the raw pins and the debouncer.
// The debouncer is the slave; whoever drives the pins is the master.
interface niosii_system_button_debounce_if #(
  parameter int NUM_BTN = 8
);
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_out;
  logic [NUM_BTN-1:0] press_pulse;
  logic [NUM_BTN-1:0] release_pulse;
  logic               busy;

  modport master (
    output btn_raw,
    input  btn_out,
    input  press_pulse,
    input  release_pulse,
    input  busy
  );

  modport slave (
    input  btn_raw,
    output btn_out,
    output press_pulse,
    output release_pulse,
    output busy
  );
endinterface

// File: rtl/niosii_system_button_debounce.sv
// Per-channel two-flop synchroniser plus IDLE/COUNT debouncer feeding the buttons PIO,
// with one-clock press/release pulses and a busy flag.
module niosii_system_button_debounce #(
  parameter int NUM_BTN         = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  niosii_system_button_debounce_if.slave btn
);

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [NUM_BTN-1:0] REL  = (ACTIVE_LOW != 0) ? {NUM_BTN{1'b1}} : {NUM_BTN{1'b0}};
  localparam logic [CNT_W-1:0]   LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] s1;
  logic [NUM_BTN-1:0] s2;
  logic [NUM_BTN-1:0] out_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] release_q;
  logic               busy_c;
  state_t             state [NUM_BTN];
  logic [CNT_W-1:0]   cnt   [NUM_BTN];

  // A change is accepted only after s2 holds the new level for the full window;
  // any reversal drops back to IDLE so the next attempt restarts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1        <= REL;
      s2        <= REL;
      out_q     <= REL;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1        <= btn.btn_raw;
      s2        <= s1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        case (state[i])
          IDLE: begin
            if (s2[i] != out_q[i]) begin
              state[i] <= COUNT;
              cnt[i]   <= '0;
            end
          end
          COUNT: begin
            if (s2[i] == out_q[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == LAST) begin
              out_q[i] <= s2[i];
              state[i] <= IDLE;
              cnt[i]   <= '0;
              if (s2[i] == REL[i]) begin
                release_q[i] <= 1'b1;
              end else begin
                press_q[i] <= 1'b1;
              end
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (state[i] == COUNT) begin
        busy_c = 1'b1;
      end
    end
  end

  assign btn.btn_out       = out_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.busy          = busy_c;

endmodule

// File: tb/tb_niosii_system_button_debounce.sv
// Directed bench for the button debouncer: expectations are queued per clock
// when a raw level is driven and compared on the falling edge of that clock.
module tb_niosii_system_button_debounce;
  localparam int NB  = 4;
  localparam int DC  = 4;
  localparam int LAT = DC + 2;

  typedef struct {
    int         cycle;
    int         stage;
    logic [3:0] out;
    logic [3:0] press;
    logic [3:0] rel;
    logic       busy;
    bit         busy_care;
  } exp_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   cyc      = 0;
  int   stage    = 0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb [$];

  niosii_system_button_debounce_if #(.NUM_BTN(NB)) bus ();

  niosii_system_button_debounce #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(3),
    .ACTIVE_LOW(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .btn(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int st, input int n,
                             input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("[TB] FAIL %s stage=%0d cycle=%0d observed=%h expected=%h", name, st, n, obs, exp_v);
    end
  endtask

  task automatic checkAll(input logic [3:0] o, input logic [3:0] p, input logic [3:0] r, input logic b);
    checkOutput("btn_out", stage, cyc, bus.btn_out, o);
    checkOutput("press_pulse", stage, cyc, bus.press_pulse, p);
    checkOutput("release_pulse", stage, cyc, bus.release_pulse, r);
    checkOutput("busy", stage, cyc, {3'b000, bus.busy}, {3'b000, b});
  endtask

  // Scoreboard consumer: every queued expectation is due on the clock it names.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cycle <= cyc) begin
      e = sb.pop_front();
      checkOutput("btn_out", e.stage, e.cycle, bus.btn_out, e.out);
      checkOutput("press_pulse", e.stage, e.cycle, bus.press_pulse, e.press);
      checkOutput("release_pulse", e.stage, e.cycle, bus.release_pulse, e.rel);
      if (e.busy_care) begin
        checkOutput("busy", e.stage, e.cycle, {3'b000, bus.busy}, {3'b000, e.busy});
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [3:0] v, output int k);
    @(negedge clk);
    bus.btn_raw = v;
    k = cyc + 1;
  endtask

  task automatic pushExp(input int n, input logic [3:0] o, input logic [3:0] p,
                         input logic [3:0] r, input logic b, input bit care);
    exp_t e;
    e.cycle = n; e.stage = stage; e.out = o; e.press = p; e.rel = r;
    e.busy = b; e.busy_care = care;
    sb.push_back(e);
  endtask

  // A level first sampled at edge k and held: busy on k+2..k+5, new level and pulse at k+6.
  task automatic expectChange(input int k, input logic [3:0] old_o, input logic [3:0] new_o,
                              input logic [3:0] p, input logic [3:0] r);
    for (int n = 0; n <= LAT + 2; n++) begin
      pushExp(k + n, (n >= LAT) ? new_o : old_o, (n == LAT) ? p : 4'h0,
              (n == LAT) ? r : 4'h0, (n >= 2 && n <= LAT - 1), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k, k0, kf, r;
    bus.btn_raw = 4'hF;

    stage = 1;
    waitCycles(2);
    #1;
    checkAll(4'hF, 4'h0, 4'h0, 1'b0);
    reset_n = 1'b1;
    r = cyc;
    for (int n = 1; n <= 20; n++) pushExp(r + n, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1);
    waitCycles(21);

    stage = 2;
    applyStimulus(4'hE, k);
    expectChange(k, 4'hF, 4'hE, 4'h1, 4'h0);
    waitCycles(10);

    stage = 3;
    applyStimulus(4'hC, k0);
    for (int n = 0; n < 8; n++) pushExp(k0 + n, 4'hE, 4'h0, 4'h0, 1'b0, 1'b0);
    waitCycles(1);
    applyStimulus(4'hE, k);
    waitCycles(1);
    applyStimulus(4'hC, k);
    waitCycles(1);
    applyStimulus(4'hE, k);
    waitCycles(1);
    applyStimulus(4'hC, kf);
    expectChange(kf, 4'hE, 4'hC, 4'h2, 4'h0);
    waitCycles(10);

    stage = 4;
    applyStimulus(4'h8, k);
    for (int n = 0; n <= 8; n++) pushExp(k + n, 4'hC, 4'h0, 4'h0, (n >= 2 && n <= 4), 1'b1);
    waitCycles(2);
    applyStimulus(4'hC, k0);
    waitCycles(8);

    stage = 5;
    applyStimulus(4'hF, k);
    expectChange(k, 4'hC, 4'hF, 4'h0, 4'h3);
    waitCycles(10);
    applyStimulus(4'h0, k);
    expectChange(k, 4'hF, 4'h0, 4'hF, 4'h0);
    waitCycles(10);
    applyStimulus(4'hF, k);
    expectChange(k, 4'h0, 4'hF, 4'h0, 4'hF);
    waitCycles(10);

    stage = 6;
    applyStimulus(4'h7, k);
    waitCycles(4);
    #1;
    checkAll(4'hF, 4'h0, 4'h0, 1'b1);
    reset_n = 1'b0;
    #1;
    checkAll(4'hF, 4'h0, 4'h0, 1'b0);
    waitCycles(2);
    #1;
    checkAll(4'hF, 4'h0, 4'h0, 1'b0);
    waitCycles(1);
    reset_n = 1'b1;
    r = cyc;
    expectChange(r + 1, 4'hF, 4'h7, 4'h8, 4'h0);
    waitCycles(10);
    applyStimulus(4'hF, k);
    expectChange(k, 4'h7, 4'hF, 4'h0, 4'h8);
    waitCycles(10);

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
